// File: rtl/feature_pkg.sv
// Shared widths, FSM encoding and the signed saturation helper for the baseline tracker.
package feature_pkg;

    localparam int LL_W      = 41;
    localparam int LL_BASE_W = 34;
    localparam int FEAT_W    = 72;
    localparam int BASE_W    = 50;
    // Wide enough for the largest accumulator (FEAT_W + 10) and the EMA sum.
    localparam int SAT_IN_W  = FEAT_W + 12;

    typedef enum logic [1:0] {IDLE, TRAIN, READY} bl_state_t;

    function automatic logic signed [SAT_IN_W-1:0] sat_signed(
        input logic signed [SAT_IN_W-1:0] v,
        input int                         w
    );
        logic signed [SAT_IN_W-1:0] lo;
        logic signed [SAT_IN_W-1:0] hi;
        lo = '1;
        lo = lo <<< (w - 1);
        hi = ~lo;
        if (v > hi)      return hi;
        else if (v < lo) return lo;
        else             return v;
    endfunction

endpackage

// File: rtl/baseline_lane.sv
// One feature lane: training accumulator, floor-mean with saturation, optional EMA tracking
// (EMA datapath exists only when BASELINE_EMA_EN is defined).
module baseline_lane
    import feature_pkg::*;
#(
    parameter int IN_W      = 72,
    parameter int OUT_W     = 50,
    parameter int LOG2_N    = 4,
    parameter int EMA_SHIFT = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             acc_en,
    input  logic             load,
`ifdef BASELINE_EMA_EN
    input  logic             ema_en,
`endif
    input  logic [IN_W-1:0]  x,
    output logic [OUT_W-1:0] base
);

    if (EMA_SHIFT < 1 || EMA_SHIFT > 16) begin : g_bad_shift
        $error("baseline_lane: EMA_SHIFT out of range");
    end

    logic signed [IN_W+LOG2_N-1:0] acc_q, acc_d;
    logic signed [OUT_W-1:0]       base_q, base_d;
    logic signed [IN_W-1:0]        x_s;
    logic signed [SAT_IN_W-1:0]    mean_ext;

    assign x_s      = x;
    assign mean_ext = SAT_IN_W'(acc_q >>> LOG2_N);

`ifdef BASELINE_EMA_EN
    logic signed [IN_W:0]       diff;
    logic signed [SAT_IN_W-1:0] ema_sum;
    assign diff    = (IN_W+1)'(x_s) - (IN_W+1)'(base_q);
    assign ema_sum = SAT_IN_W'(base_q) + SAT_IN_W'(diff >>> EMA_SHIFT);
`endif

    always_comb begin
        acc_d  = acc_q;
        base_d = base_q;
        if (clr)         acc_d = '0;
        else if (acc_en) acc_d = acc_q + x_s;
        if (load)        base_d = OUT_W'(sat_signed(mean_ext, OUT_W));
`ifdef BASELINE_EMA_EN
        else if (ema_en) base_d = OUT_W'(sat_signed(ema_sum, OUT_W));
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q  <= '0;
            base_q <= '0;
        end else begin
            acc_q  <= acc_d;
            base_q <= base_d;
        end
    end

    assign base = base_q;

endmodule

// File: rtl/feature_baseline_tracker.sv
// Six-lane feature baseline tracker: averages 2^LOG2_N training windows, then holds the mean.
// Define BASELINE_EMA_EN to let baselines follow the features by EMA once trained.
module feature_baseline_tracker
    import feature_pkg::*;
#(
    parameter int LOG2_N    = 4,
    parameter int EMA_SHIFT = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 feat_valid,
    input  logic [LL_W-1:0]      ll_out,
    input  logic [FEAT_W-1:0]    ne_out,
    input  logic [FEAT_W-1:0]    ps_out,
    input  logic [FEAT_W-1:0]    theta_out,
    input  logic [FEAT_W-1:0]    alpha_out,
    input  logic [FEAT_W-1:0]    beta_out,
    output logic [LL_BASE_W-1:0] ll_base,
    output logic [BASE_W-1:0]    ne_base,
    output logic [BASE_W-1:0]    ps_base,
    output logic [BASE_W-1:0]    theta_base,
    output logic [BASE_W-1:0]    alpha_base,
    output logic [BASE_W-1:0]    beta_base,
    output logic                 base_valid,
    output logic                 training
);

    if (LOG2_N < 1 || LOG2_N > 10) begin : g_bad_n
        $error("feature_baseline_tracker: LOG2_N out of range");
    end

    localparam logic [LOG2_N:0] N_CNT = {1'b1, {LOG2_N{1'b0}}};

    bl_state_t       state_q, state_d;
    logic [LOG2_N:0] win_cnt_q, win_cnt_d;
    logic            base_valid_q, base_valid_d;
    logic            clr, acc_en, load;
`ifdef BASELINE_EMA_EN
    logic            ema_en;
`endif

    always_comb begin
        state_d      = state_q;
        win_cnt_d    = win_cnt_q;
        base_valid_d = base_valid_q;
        clr          = 1'b0;
        acc_en       = 1'b0;
        load         = 1'b0;
`ifdef BASELINE_EMA_EN
        ema_en       = 1'b0;
`endif
        // start wins over everything, including a completing run and this cycle's window.
        if (start) begin
            state_d      = TRAIN;
            win_cnt_d    = '0;
            base_valid_d = 1'b0;
            clr          = 1'b1;
        end else begin
            case (state_q)
                TRAIN: begin
                    if (win_cnt_q == N_CNT) begin
                        load         = 1'b1;
                        base_valid_d = 1'b1;
                        state_d      = READY;
                    end else if (feat_valid) begin
                        acc_en    = 1'b1;
                        win_cnt_d = win_cnt_q + (LOG2_N+1)'(1);
                    end
                end
                READY: begin
`ifdef BASELINE_EMA_EN
                    ema_en = feat_valid;
`endif
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            win_cnt_q    <= '0;
            base_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            win_cnt_q    <= win_cnt_d;
            base_valid_q <= base_valid_d;
        end
    end

    assign base_valid = base_valid_q;
    assign training   = (state_q == TRAIN);

    baseline_lane #(.IN_W(LL_W), .OUT_W(LL_BASE_W), .LOG2_N(LOG2_N), .EMA_SHIFT(EMA_SHIFT)) u_ll (
        .clk    (clk),
        .rst    (rst),
        .clr    (clr),
        .acc_en (acc_en),
        .load   (load),
`ifdef BASELINE_EMA_EN
        .ema_en (ema_en),
`endif
        .x      (ll_out),
        .base   (ll_base)
    );

    logic [4:0][FEAT_W-1:0] feat_in;
    logic [4:0][BASE_W-1:0] base_out;

    assign feat_in = {beta_out, alpha_out, theta_out, ps_out, ne_out};
    assign {beta_base, alpha_base, theta_base, ps_base, ne_base} = base_out;

    for (genvar i = 0; i < 5; i++) begin : g_lane
        baseline_lane #(.IN_W(FEAT_W), .OUT_W(BASE_W), .LOG2_N(LOG2_N), .EMA_SHIFT(EMA_SHIFT)) u_lane (
            .clk    (clk),
            .rst    (rst),
            .clr    (clr),
            .acc_en (acc_en),
            .load   (load),
`ifdef BASELINE_EMA_EN
            .ema_en (ema_en),
`endif
            .x      (feat_in[i]),
            .base   (base_out[i])
        );
    end

endmodule

// File: tb/tb_feature_baseline_tracker.sv
// Bench for feature_baseline_tracker: table of training runs, corner sequences, random run vs model.
module tb_feature_baseline_tracker;

    localparam int LOG2_N    = 2;
    localparam int EMA_SHIFT = 2;
    localparam int N         = 1 << LOG2_N;

    logic        clk = 1'b0;
    logic        rst, start, feat_valid;
    logic [40:0] ll_out;
    logic [71:0] ne_out, ps_out, theta_out, alpha_out, beta_out;
    logic [33:0] ll_base;
    logic [49:0] ne_base, ps_base, theta_base, alpha_base, beta_base;
    logic        base_valid, training;

    always #5 clk = ~clk;

    feature_baseline_tracker #(.LOG2_N(LOG2_N), .EMA_SHIFT(EMA_SHIFT)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .feat_valid (feat_valid),
        .ll_out     (ll_out),
        .ne_out     (ne_out),
        .ps_out     (ps_out),
        .theta_out  (theta_out),
        .alpha_out  (alpha_out),
        .beta_out   (beta_out),
        .ll_base    (ll_base),
        .ne_base    (ne_base),
        .ps_base    (ps_base),
        .theta_base (theta_base),
        .alpha_base (alpha_base),
        .beta_base  (beta_base),
        .base_valid (base_valid),
        .training   (training)
    );

    int checks = 0;
    int failures = 0;

    // Reference model: running sums of the current training run, published as floor means.
    longint m_sum [6];
    longint m_base[6];
    int     m_cnt;
    int     m_phase;   // 0 idle, 1 training, 2 trained
    bit     m_pend;    // N windows collected, result publishes next cycle
    bit     m_bvalid;

    function automatic longint fdiv(longint a, int sh);
        longint d, q;
        d = longint'(1) <<< sh;
        q = a / d;
        if ((a % d) != 0 && a < 0) q = q - 1;
        return q;
    endfunction

    function automatic longint sat(longint v, int w);
        longint hi, lo;
        hi = (longint'(1) <<< (w - 1)) - 1;
        lo = -hi - 1;
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    function automatic int lane_w(int i);
        return (i == 0) ? 34 : 50;
    endfunction

    task automatic chk(string name, longint act, longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic check_all(string tag);
        longint act[6];
        act[0] = longint'($signed(ll_base));
        act[1] = longint'($signed(ne_base));
        act[2] = longint'($signed(ps_base));
        act[3] = longint'($signed(theta_base));
        act[4] = longint'($signed(alpha_base));
        act[5] = longint'($signed(beta_base));
        for (int i = 0; i < 6; i++) chk($sformatf("%s/base%0d", tag, i), act[i], m_base[i]);
        chk($sformatf("%s/base_valid", tag), longint'(base_valid), longint'(m_bvalid));
        chk($sformatf("%s/training", tag), longint'(training), longint'(m_phase == 1));
    endtask

    task automatic model_reset();
        for (int i = 0; i < 6; i++) begin
            m_sum[i]  = 0;
            m_base[i] = 0;
        end
        m_cnt = 0; m_phase = 0; m_pend = 0; m_bvalid = 0;
    endtask

    // Drive one cycle, advance the model by the same cycle, then compare everything.
    task automatic cyc(string tag, bit st, bit fv, input longint x[6]);
        start      = st;
        feat_valid = fv;
        ll_out     = x[0][40:0];
        ne_out     = {{8{x[1][63]}}, x[1]};
        ps_out     = {{8{x[2][63]}}, x[2]};
        theta_out  = {{8{x[3][63]}}, x[3]};
        alpha_out  = {{8{x[4][63]}}, x[4]};
        beta_out   = {{8{x[5][63]}}, x[5]};
        if (st) begin
            for (int i = 0; i < 6; i++) m_sum[i] = 0;
            m_cnt = 0; m_pend = 0; m_bvalid = 0; m_phase = 1;
        end else if (m_phase == 1) begin
            if (m_pend) begin
                for (int i = 0; i < 6; i++) m_base[i] = sat(fdiv(m_sum[i], LOG2_N), lane_w(i));
                m_bvalid = 1; m_phase = 2; m_pend = 0;
            end else if (fv) begin
                for (int i = 0; i < 6; i++) m_sum[i] += x[i];
                m_cnt++;
                if (m_cnt == N) m_pend = 1;
            end
        end else if (m_phase == 2 && fv) begin
`ifdef BASELINE_EMA_EN
            for (int i = 0; i < 6; i++)
                m_base[i] = sat(m_base[i] + fdiv(x[i] - m_base[i], EMA_SHIFT), lane_w(i));
`endif
        end
        @(posedge clk);
        #1;
        start      = 1'b0;
        feat_valid = 1'b0;
        check_all(tag);
    endtask

    function automatic longint rnd(int w);
        bit [63:0] r;
        longint    s;
        r = {$urandom, $urandom};
        s = longint'(r);
        if ($urandom_range(3) == 0) return s >>> 56;
        return s >>> (64 - w);
    endfunction

    typedef struct {
        longint ll0, ll1, ll2, ll3;
        longint ne;
        longint exp_ll;
        longint exp_ne;
    } vec_t;

    vec_t   tbl[6];
    longint xv[6];
    longint zero6[6];
    longint lls[4];

    // Full training run with the same wide-lane value in every window.
    task automatic train(string tag, longint l0, longint l1, longint l2, longint l3, longint wide);
        lls[0] = l0; lls[1] = l1; lls[2] = l2; lls[3] = l3;
        cyc({tag, "/start"}, 1'b1, 1'b0, zero6);
        for (int w = 0; w < N; w++) begin
            xv[0] = lls[w];
            for (int i = 1; i < 6; i++) xv[i] = wide;
            cyc({tag, "/win"}, 1'b0, 1'b1, xv);
        end
        chk({tag, "/training_before_done"}, longint'(training), 1);
        chk({tag, "/valid_before_done"}, longint'(base_valid), 0);
        cyc({tag, "/done"}, 1'b0, 1'b0, zero6);
    endtask

    initial begin
        for (int i = 0; i < 6; i++) zero6[i] = 0;
        tbl[0] = '{10, 20, 30, 40, 0, 25, 0};
        tbl[1] = '{-1, -2, -2, -2, -8, -2, -8};
        tbl[2] = '{0, 0, 0, 0, longint'(1) <<< 60, 0, (longint'(1) <<< 49) - 1};
        tbl[3] = '{1, 1, 1, 1, -(longint'(1) <<< 60), 1, -(longint'(1) <<< 49)};
        tbl[4] = '{(longint'(1) <<< 40) - 1, (longint'(1) <<< 40) - 1, (longint'(1) <<< 40) - 1,
                   (longint'(1) <<< 40) - 1, 7, (longint'(1) <<< 33) - 1, 7};
        tbl[5] = '{-(longint'(1) <<< 40), -(longint'(1) <<< 40), -(longint'(1) <<< 40),
                   -(longint'(1) <<< 40), -5, -(longint'(1) <<< 33), -5};

        rst = 1'b1; start = 1'b0; feat_valid = 1'b0;
        ll_out = '0; ne_out = '0; ps_out = '0; theta_out = '0; alpha_out = '0; beta_out = '0;
        model_reset();
        #3;
        check_all("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        for (int k = 0; k < 6; k++) begin
            train($sformatf("tbl%0d", k), tbl[k].ll0, tbl[k].ll1, tbl[k].ll2, tbl[k].ll3, tbl[k].ne);
            chk($sformatf("tbl%0d/ll_base", k), longint'($signed(ll_base)), tbl[k].exp_ll);
            chk($sformatf("tbl%0d/ne_base", k), longint'($signed(ne_base)), tbl[k].exp_ne);
            chk($sformatf("tbl%0d/beta_base", k), longint'($signed(beta_base)), tbl[k].exp_ne);
            chk($sformatf("tbl%0d/base_valid", k), longint'(base_valid), 1);
            chk($sformatf("tbl%0d/training", k), longint'(training), 0);
        end

        // Retrain from READY: valid drops at once, old baseline held, start-cycle window discarded.
        train("hold25", 10, 20, 30, 40, 0);
        xv = zero6; xv[0] = 1000;
        cyc("retrain/start", 1'b1, 1'b1, xv);
        chk("retrain/valid_drop", longint'(base_valid), 0);
        chk("retrain/ll_held", longint'($signed(ll_base)), 25);
        for (int w = 0; w < N; w++) begin
            xv[0] = 100;
            cyc("retrain/win", 1'b0, 1'b1, xv);
            chk("retrain/ll_held_during", longint'($signed(ll_base)), 25);
        end
        cyc("retrain/done", 1'b0, 1'b0, zero6);
        chk("retrain/ll_100", longint'($signed(ll_base)), 100);

        // start while training restarts the run.
        cyc("restart/start", 1'b1, 1'b0, zero6);
        xv = zero6; xv[0] = 500;
        cyc("restart/w0", 1'b0, 1'b1, xv);
        cyc("restart/w1", 1'b0, 1'b1, xv);
        cyc("restart/again", 1'b1, 1'b1, xv);
        xv[0] = 8;
        for (int w = 0; w < N; w++) cyc("restart/win", 1'b0, 1'b1, xv);
        cyc("restart/done", 1'b0, 1'b0, zero6);
        chk("restart/ll_8", longint'($signed(ll_base)), 8);

        // Async reset in the middle of a run, then windows in IDLE are ignored.
        cyc("rst/start", 1'b1, 1'b0, zero6);
        xv[0] = 60;
        cyc("rst/w0", 1'b0, 1'b1, xv);
        cyc("rst/w1", 1'b0, 1'b1, xv);
        rst = 1'b1;
        model_reset();
        #2;
        check_all("rst/async");
        chk("rst/ll_zero", longint'($signed(ll_base)), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        xv[0] = 77; xv[1] = 1234;
        cyc("idle/fv0", 1'b0, 1'b1, xv);
        cyc("idle/fv1", 1'b0, 1'b1, xv);
        chk("idle/ll_zero", longint'($signed(ll_base)), 0);
        chk("idle/valid", longint'(base_valid), 0);

        // Windows after training: EMA tracking when enabled, frozen otherwise.
        train("ema_pre", 100, 100, 100, 100, 0);
        xv = zero6; xv[0] = 140;
        cyc("ema/upd", 1'b0, 1'b1, xv);
`ifdef BASELINE_EMA_EN
        chk("ema/ll_110", longint'($signed(ll_base)), 110);
`else
        chk("ema/ll_frozen", longint'($signed(ll_base)), 100);
`endif
        chk("ema/valid_stays", longint'(base_valid), 1);

        // Random traffic against the model.
        cyc("rand/start", 1'b1, 1'b0, zero6);
        for (int c = 0; c < 400; c++) begin
            xv[0] = rnd(41);
            for (int i = 1; i < 6; i++) xv[i] = rnd(61);
            cyc("rand", ($urandom_range(29) == 0), ($urandom_range(2) != 0), xv);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL timeout actual=running required=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
